spi_settings_slave: RTL

- SPI slave (mode 0, MSB first) that lets an external SPI master (the FX3) access the FPGA settings bus and readback bus.
- Oversamples the SPI pins in the bus clock domain.
- Converts 40-bit SPI frames into single-cycle settings writes or readback requests.
- Drives MISO with an output enable. Sits beside the core's SPI master and is the responder end of the same serial protocol.

---
 rtl/spi_settings_slave.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/spi_settings_slave.sv
// SPI mode-0 responder bridging 40-bit frames from the FX3 onto the settings
// and readback buses; all SPI pins are oversampled in the clk domain.
module spi_settings_slave #(
  parameter int          AWIDTH          = 7,
  parameter int          SYNC_STAGES     = 2,
  parameter logic [31:0] RB_TIMEOUT_DATA = 32'hDEADBEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_sclk,
  input  logic              spi_sen,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic              set_stb,
  output logic [7:0]        set_addr,
  output logic [31:0]       set_data,
  output logic              rb_stb,
  output logic [7:0]        rb_addr,
  input  logic              rb_ack,
  input  logic [31:0]       rb_data,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CMD,
    S_WDATA,
    S_RD_WAIT,
    S_RDATA,
    S_DONE
  } state_t;

  state_t state, state_next;

  logic [SYNC_STAGES-1:0] sclk_sr, sen_sr, mosi_sr;
  logic                   sclk_s, sen_s, mosi_s;
  logic                   sclk_q, sen_act_q;
  logic                   rise, fall, sen_act, sen_start;

  logic [5:0]        bit_cnt;
  logic [30:0]       rx;
  logic [AWIDTH-1:0] addr;
  logic              is_read;
  logic [31:0]       tx;

  logic        cmd_rise, last_rise;
  logic        cmd_latch, rb_fire, set_fire, err_fire;
  logic        tx_load, tx_present;
  logic [31:0] tx_word;

  assign sclk_s    = sclk_sr[SYNC_STAGES-1];
  assign sen_s     = sen_sr[SYNC_STAGES-1];
  assign mosi_s    = mosi_sr[SYNC_STAGES-1];
  assign rise      = sclk_s & ~sclk_q;
  assign fall      = ~sclk_s & sclk_q;
  assign sen_act   = ~sen_s;
  assign sen_start = sen_act & ~sen_act_q;
  assign cmd_rise  = rise && (bit_cnt == 6'd7);
  assign last_rise = rise && (bit_cnt == 6'd39);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_sr   <= '0;
      sen_sr    <= '1;
      mosi_sr   <= '0;
      sclk_q    <= 1'b0;
      sen_act_q <= 1'b0;
    end else begin
      sclk_sr   <= {sclk_sr[SYNC_STAGES-2:0], spi_sclk};
      sen_sr    <= {sen_sr[SYNC_STAGES-2:0], spi_sen};
      mosi_sr   <= {mosi_sr[SYNC_STAGES-2:0], spi_mosi};
      sclk_q    <= sclk_s;
      sen_act_q <= sen_act;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  // A 40th rise seen together with sen release still completes the frame.
  always_comb begin
    state_next = state;
    cmd_latch  = 1'b0;
    rb_fire    = 1'b0;
    set_fire   = 1'b0;
    err_fire   = 1'b0;
    tx_load    = 1'b0;
    tx_present = 1'b0;
    tx_word    = rb_data;
    case (state)
      S_IDLE: if (sen_start) state_next = S_CMD;
      S_CMD: begin
        if (!sen_act) begin
          state_next = S_IDLE;
          err_fire   = 1'b1;
        end else if (cmd_rise) begin
          cmd_latch = 1'b1;
          if (rx[6]) begin
            state_next = S_RD_WAIT;
            rb_fire    = 1'b1;
          end else begin
            state_next = S_WDATA;
          end
        end
      end
      S_WDATA: begin
        if (last_rise) begin
          set_fire   = 1'b1;
          state_next = sen_act ? S_DONE : S_IDLE;
        end else if (!sen_act) begin
          state_next = S_IDLE;
          err_fire   = 1'b1;
        end
      end
      S_RD_WAIT: begin
        if (!sen_act) begin
          state_next = S_IDLE;
          err_fire   = 1'b1;
        end else if (fall) begin
          tx_present = 1'b1;
          state_next = S_RDATA;
          if (!rb_ack) begin
            tx_word  = RB_TIMEOUT_DATA;
            err_fire = 1'b1;
          end
        end else if (rb_ack) begin
          tx_load    = 1'b1;
          state_next = S_RDATA;
        end
      end
      S_RDATA: begin
        tx_word = tx;
        if (last_rise) begin
          state_next = sen_act ? S_DONE : S_IDLE;
        end else if (!sen_act) begin
          state_next = S_IDLE;
          err_fire   = 1'b1;
        end else if (fall) begin
          tx_present = 1'b1;
        end
      end
      S_DONE: if (!sen_act) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      rx        <= '0;
      addr      <= '0;
      is_read   <= 1'b0;
      tx        <= '0;
      spi_miso  <= 1'b0;
      set_stb   <= 1'b0;
      set_addr  <= '0;
      set_data  <= '0;
      rb_stb    <= 1'b0;
      rb_addr   <= '0;
      frame_err <= 1'b0;
    end else begin
      set_stb   <= 1'b0;
      rb_stb    <= 1'b0;
      frame_err <= err_fire;
      if (state == S_IDLE) begin
        bit_cnt <= '0;
        rx      <= '0;
      end else if (rise && sen_act) begin
        rx <= {rx[29:0], mosi_s};
        if (bit_cnt != 6'd40) bit_cnt <= bit_cnt + 6'd1;
      end
      if (cmd_latch) begin
        is_read <= rx[6];
        addr    <= AWIDTH'({rx[5:0], mosi_s});
      end
      if (rb_fire) begin
        rb_stb  <= 1'b1;
        rb_addr <= {1'b0, rx[5:0], mosi_s};
      end
      if (set_fire) begin
        set_stb  <= 1'b1;
        set_addr <= {1'b0, addr};
        set_data <= {rx[30:0], mosi_s};
      end
      if (tx_load) tx <= rb_data;
      if (tx_present) begin
        spi_miso <= tx_word[31];
        tx       <= {tx_word[30:0], 1'b0};
      end else if (state_next == S_IDLE || state_next == S_DONE) begin
        spi_miso <= 1'b0;
      end
    end
  end

  always_comb begin
    spi_miso_oe = sen_act && ((state == S_RDATA) || (state == S_DONE && is_read));
  end

endmodule
